// File: rtl/turn_if.sv
// Move/board bundle between the input conditioning, the turn controller and the display side.
// master drives requests and AI suggestions; slave is the controller.
interface turn_if #(
  parameter int unsigned WIN_W = 8
) ();
  logic             tick_en;
  logic             new_game;
  logic             move_req;
  logic [3:0]       move_idx;
  logic             ai_enable;
  logic             ai_hard;
  logic [8:0]       ai_move_easy;
  logic [8:0]       ai_move_hard;
  logic [8:0]       x_board;
  logic [8:0]       o_board;
  logic [2:0]       status;
  logic [WIN_W-1:0] win_count;
  logic             busy;
  logic             illegal;

  modport master (
    output tick_en, new_game, move_req, move_idx, ai_enable, ai_hard, ai_move_easy, ai_move_hard,
    input  x_board, o_board, status, win_count, busy, illegal
  );

  modport slave (
    input  tick_en, new_game, move_req, move_idx, ai_enable, ai_hard, ai_move_easy, ai_move_hard,
    output x_board, o_board, status, win_count, busy, illegal
  );
endinterface

// File: rtl/turn_controller.sv
// Tic-tac-toe game sequencer: owns both boards, arbitrates human and AI moves, detects
// win/draw and keeps a saturating count of X wins.
module turn_controller #(
  parameter int unsigned AI_DELAY = 4,
  parameter int unsigned WIN_W    = 8
) (
  input logic   clk,
  input logic   clr,
  turn_if.slave bus
);

  typedef enum logic [3:0] {
    StXTurn, StOTurn, StCheckX, StCheckO, StAiWait, StAiCommit, StXWin, StOWin, StDraw
  } state_e;

  state_e           r_state;
  logic [8:0]       r_x_board, r_o_board;
  logic [2:0]       r_status;
  logic [WIN_W-1:0] r_win_count;
  logic             r_busy, r_illegal, r_pend;
  logic [3:0]       r_idx;
  logic [7:0]       r_cnt;

  logic [8:0] w_occ, w_cell, w_ai_src, w_ai_pick, w_fallback;
  logic       w_full, w_legal, w_ai_onehot, w_x_win, w_o_win;

  function automatic logic has_line(input logic [8:0] b);
    return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  assign w_occ       = r_x_board | r_o_board;
  assign w_full      = &w_occ;
  assign w_cell      = 9'b1 << r_idx;
  assign w_legal     = (r_idx <= 4'd8) && ((w_occ & w_cell) == 9'd0);
  assign w_x_win     = has_line(r_x_board);
  assign w_o_win     = has_line(r_o_board);
  assign w_ai_src    = bus.ai_hard ? bus.ai_move_hard : bus.ai_move_easy;
  assign w_ai_onehot = (w_ai_src != 9'd0) && ((w_ai_src & (w_ai_src - 9'd1)) == 9'd0);
  // Trust the AI only for a single empty cell; anything else falls back to the lowest free cell.
  assign w_ai_pick   = (w_ai_onehot && ((w_ai_src & w_occ) == 9'd0)) ? w_ai_src : w_fallback;

  always_comb begin
    w_fallback = 9'd0;
    for (int i = 8; i >= 0; i--) begin
      if (!w_occ[i]) w_fallback = 9'b1 << i;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= StXTurn;
      r_x_board   <= 9'd0;
      r_o_board   <= 9'd0;
      r_status    <= 3'd0;
      r_win_count <= '0;
      r_busy      <= 1'b0;
      r_illegal   <= 1'b0;
      r_pend      <= 1'b0;
      r_idx       <= 4'd0;
      r_cnt       <= 8'd0;
    end else if (bus.new_game) begin
      r_state   <= StXTurn;
      r_x_board <= 9'd0;
      r_o_board <= 9'd0;
      r_status  <= 3'd0;
      r_busy    <= 1'b0;
      r_illegal <= 1'b0;
      r_pend    <= 1'b0;
      r_cnt     <= 8'd0;
    end else begin
      r_illegal <= 1'b0;
      if (bus.move_req) begin
        r_pend <= 1'b1;
        r_idx  <= bus.move_idx;
      end else if (bus.tick_en) begin
        r_pend <= 1'b0;
      end
      if (bus.tick_en) begin
        case (r_state)
          StXTurn, StOTurn: begin
            if (r_pend) begin
              if (!w_legal) begin
                r_illegal <= 1'b1;
              end else if (r_state == StXTurn) begin
                r_x_board <= r_x_board | w_cell;
                r_state   <= StCheckX;
              end else begin
                r_o_board <= r_o_board | w_cell;
                r_state   <= StCheckO;
              end
            end
          end
          StCheckX: begin
            if (w_x_win) begin
              r_state  <= StXWin;
              r_status <= 3'd3;
              if (!(&r_win_count)) r_win_count <= r_win_count + {{(WIN_W-1){1'b0}}, 1'b1};
            end else if (w_full) begin
              r_state  <= StDraw;
              r_status <= 3'd5;
            end else if (bus.ai_enable) begin
              r_state  <= StAiWait;
              r_status <= 3'd2;
              r_busy   <= 1'b1;
              r_cnt    <= 8'd0;
            end else begin
              r_state  <= StOTurn;
              r_status <= 3'd1;
            end
          end
          StCheckO: begin
            if (w_o_win) begin
              r_state  <= StOWin;
              r_status <= 3'd4;
            end else if (w_full) begin
              r_state  <= StDraw;
              r_status <= 3'd5;
            end else begin
              r_state  <= StXTurn;
              r_status <= 3'd0;
            end
          end
          StAiWait: begin
            if (r_cnt == 8'(AI_DELAY - 1)) r_state <= StAiCommit;
            else                           r_cnt   <= r_cnt + 8'd1;
          end
          StAiCommit: begin
            r_o_board <= r_o_board | w_ai_pick;
            r_state   <= StCheckO;
            r_busy    <= 1'b0;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign bus.x_board   = r_x_board;
  assign bus.o_board   = r_o_board;
  assign bus.status    = r_status;
  assign bus.win_count = r_win_count;
  assign bus.busy      = r_busy;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: vector table of human moves plus hand-written AI,
// new_game, saturation and reset sequences.
module tb_turn_controller;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  turn_if #(.WIN_W(8)) bus ();

  turn_controller #(.AI_DELAY(4), .WIN_W(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic       ng;
    logic [3:0] idx;
    logic       ill;
    logic [8:0] x;
    logic [8:0] o;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_wins = 0;
  logic [2:0] prev_st;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic t);
    bus.tick_en = t;
    @(negedge clk);
    bus.tick_en = 1'b0;
  endtask

  task automatic req(input logic [3:0] idx);
    bus.move_req = 1'b1;
    bus.move_idx = idx;
    @(negedge clk);
    bus.move_req = 1'b0;
  endtask

  task automatic pulse_ng();
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  task automatic human(input logic [3:0] idx);
    req(idx);
    step(1'b1);
    step(1'b1);
  endtask

  task automatic ai_run();
    repeat (4) step(1'b1);
    step(1'b1);
    step(1'b1);
  endtask

  initial begin
    bus.tick_en = 0; bus.new_game = 0; bus.move_req = 0; bus.move_idx = 0;
    bus.ai_enable = 0; bus.ai_hard = 0; bus.ai_move_easy = 0; bus.ai_move_hard = 0;
    repeat (2) @(negedge clk);
    chk("rst_x", bus.x_board, 0);
    chk("rst_o", bus.o_board, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_wins", bus.win_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_illegal", bus.illegal, 0);
    clr = 1'b0;
    @(negedge clk);

    // Game 1: X wins on the diagonal, then a request in the terminal state is ignored.
    vecs.push_back('{ng:0, idx:0, ill:0, x:9'h001, o:9'h000, st:1});
    vecs.push_back('{ng:0, idx:1, ill:0, x:9'h001, o:9'h002, st:0});
    vecs.push_back('{ng:0, idx:4, ill:0, x:9'h011, o:9'h002, st:1});
    vecs.push_back('{ng:0, idx:2, ill:0, x:9'h011, o:9'h006, st:0});
    vecs.push_back('{ng:0, idx:8, ill:0, x:9'h111, o:9'h006, st:3});
    vecs.push_back('{ng:0, idx:5, ill:0, x:9'h111, o:9'h006, st:3});
    // Game 2: occupied cell and out-of-range index on O's turn.
    vecs.push_back('{ng:1, idx:4, ill:0, x:9'h010, o:9'h000, st:1});
    vecs.push_back('{ng:0, idx:4, ill:1, x:9'h010, o:9'h000, st:1});
    vecs.push_back('{ng:0, idx:9, ill:1, x:9'h010, o:9'h000, st:1});
    vecs.push_back('{ng:0, idx:0, ill:0, x:9'h010, o:9'h001, st:0});
    // Game 3: full board without a line.
    vecs.push_back('{ng:1, idx:0, ill:0, x:9'h001, o:9'h000, st:1});
    vecs.push_back('{ng:0, idx:1, ill:0, x:9'h001, o:9'h002, st:0});
    vecs.push_back('{ng:0, idx:2, ill:0, x:9'h005, o:9'h002, st:1});
    vecs.push_back('{ng:0, idx:4, ill:0, x:9'h005, o:9'h012, st:0});
    vecs.push_back('{ng:0, idx:3, ill:0, x:9'h00D, o:9'h012, st:1});
    vecs.push_back('{ng:0, idx:5, ill:0, x:9'h00D, o:9'h032, st:0});
    vecs.push_back('{ng:0, idx:7, ill:0, x:9'h08D, o:9'h032, st:1});
    vecs.push_back('{ng:0, idx:6, ill:0, x:9'h08D, o:9'h072, st:0});
    vecs.push_back('{ng:0, idx:8, ill:0, x:9'h18D, o:9'h072, st:5});

    prev_st = 3'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ng) begin
        pulse_ng();
        prev_st = 3'd0;
      end
      req(vecs[i].idx);
      step(1'b1);
      chk($sformatf("v%0d_illegal", i), bus.illegal, vecs[i].ill);
      chk($sformatf("v%0d_status_mid", i), bus.status, prev_st);
      step(1'b1);
      chk($sformatf("v%0d_illegal_once", i), bus.illegal, 0);
      chk($sformatf("v%0d_x", i), bus.x_board, vecs[i].x);
      chk($sformatf("v%0d_o", i), bus.o_board, vecs[i].o);
      chk($sformatf("v%0d_status", i), bus.status, vecs[i].st);
      prev_st = vecs[i].st;
    end
    exp_wins = 1;
    chk("wins_after_tables", bus.win_count, exp_wins);

    // AI one-hot move, with a human request during AI_WAIT discarded silently.
    pulse_ng();
    bus.ai_enable = 1; bus.ai_move_easy = 9'h001;
    human(4);
    chk("ai_enter_status", bus.status, 2);
    chk("ai_enter_busy", bus.busy, 1);
    req(0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ai_wait%0d_status", k), bus.status, 2);
      chk($sformatf("ai_wait%0d_busy", k), bus.busy, 1);
      chk($sformatf("ai_wait%0d_illegal", k), bus.illegal, 0);
      chk($sformatf("ai_wait%0d_o", k), bus.o_board, 0);
      step(1'b1);
      @(negedge clk);
    end
    chk("ai_commit_busy", bus.busy, 1);
    chk("ai_commit_x", bus.x_board, 9'h010);
    step(1'b1);
    chk("ai_o", bus.o_board, 9'h001);
    chk("ai_checko_busy", bus.busy, 0);
    chk("ai_checko_status", bus.status, 2);
    step(1'b1);
    chk("ai_back_status", bus.status, 0);

    // Fallback: two-bit source, then one-hot source on an occupied cell.
    pulse_ng();
    bus.ai_move_easy = 9'h011; bus.ai_move_hard = 9'h001; bus.ai_hard = 0;
    human(0);
    ai_run();
    chk("fb_multi_o", bus.o_board, 9'h002);
    chk("fb_multi_status", bus.status, 0);
    human(2);
    bus.ai_hard = 1;
    ai_run();
    chk("fb_occ_x", bus.x_board, 9'h005);
    chk("fb_occ_o", bus.o_board, 9'h00A);
    bus.ai_hard = 0;

    // new_game in the middle of AI_WAIT.
    pulse_ng();
    human(5);
    step(1'b1);
    chk("ng_wait_busy_pre", bus.busy, 1);
    pulse_ng();
    chk("ng_wait_x", bus.x_board, 0);
    chk("ng_wait_o", bus.o_board, 0);
    chk("ng_wait_status", bus.status, 0);
    chk("ng_wait_busy", bus.busy, 0);
    chk("ng_wait_wins", bus.win_count, exp_wins);
    bus.ai_enable = 0;

    // new_game wins over a same-clock move_req.
    bus.new_game = 1; bus.move_req = 1; bus.move_idx = 0;
    @(negedge clk);
    bus.new_game = 0; bus.move_req = 0;
    step(1'b1);
    step(1'b1);
    chk("ng_prio_x", bus.x_board, 0);
    chk("ng_prio_status", bus.status, 0);

    // 256 quick X wins: counter must stop at all-ones.
    for (int g = 0; g < 256; g++) begin
      pulse_ng();
      human(0); human(3); human(1); human(4); human(2);
      if (exp_wins < 255) exp_wins++;
      chk($sformatf("sat%0d_status", g), bus.status, 3);
      chk($sformatf("sat%0d_wins", g), bus.win_count, exp_wins);
    end
    chk("sat_final", bus.win_count, 255);

    // Asynchronous clear mid-game.
    pulse_ng();
    human(0);
    chk("clr_pre_x", bus.x_board, 9'h001);
    #1 clr = 1'b1;
    #1;
    chk("clr_x", bus.x_board, 0);
    chk("clr_o", bus.o_board, 0);
    chk("clr_status", bus.status, 0);
    chk("clr_wins", bus.win_count, 0);
    chk("clr_busy", bus.busy, 0);
    chk("clr_illegal", bus.illegal, 0);
    @(negedge clk);
    clr = 1'b0;
    human(7);
    chk("clr_after_x", bus.x_board, 9'h080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
